// File: rtl/addsub_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
//   Shared types and defaults for the serial adder/subtractor.
//   - state_t      : controller states (IDLE, RUN, DONE)
//   - DEF_WIDTH    : default operand/result width
//   - DEF_SLICE_W  : default bits processed per RUN cycle
//   - idx_width()  : slice-index counter width, never below one bit
// -----------------------------------------------------------------------------
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_SLICE_W = 4;

  // A single-slice configuration still needs a one-bit counter to exist.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : addsub_pkg

// File: rtl/addsub_slice.sv
// -----------------------------------------------------------------------------
// addsub_slice
//   Combinational W-bit ripple-carry adder built from full adders.
//   Ports:
//     cout : carry out of the most significant bit
//     sum  : W-bit sum of a + b + cin
//     a, b : W-bit addends (b arrives already inverted for subtraction)
//     cin  : carry in from the previous slice
// -----------------------------------------------------------------------------
module addsub_slice #(
  parameter int W = 4
) (
  output logic         cout,
  output logic [W-1:0] sum,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin
);

  always_comb begin
    logic c;
    c   = cin;
    sum = '0;
    for (int i = 0; i < W; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule : addsub_slice

// File: rtl/addsub_serial.sv
// -----------------------------------------------------------------------------
// addsub_serial
//   Multi-cycle adder/subtractor processing SLICE_W bits per clock.
//   sub=0 computes a+b, sub=1 computes a-b as a + ~b + 1. Result and carry
//   match a full-width ripple-carry adder bit for bit.
//   Ports:
//     clk, rst_n            : clock (rising edge), async active-low reset
//     in_valid / in_ready   : request handshake; a, b, sub sampled on accept
//     a, b                  : WIDTH-bit operands
//     sub                   : 0 = add, 1 = subtract
//     out_valid / out_ready : response handshake; sum, cout held until taken
//     sum                   : WIDTH-bit result, modulo 2^WIDTH
//     cout                  : carry out; for subtraction 1 means a >= b
//   Latency: out_valid rises WIDTH/SLICE_W edges after the accept edge.
// -----------------------------------------------------------------------------
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SLICE_W = DEF_SLICE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int N     = WIDTH / SLICE_W;
  localparam int IDX_W = idx_width(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  if (WIDTH % SLICE_W != 0) begin : g_bad_slice
    $error("addsub_serial: WIDTH (%0d) must be a multiple of SLICE_W (%0d)",
           WIDTH, SLICE_W);
  end

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;
  logic               cout_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;     // already inverted when subtracting
  logic [WIDTH-1:0]   sum_q;

  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;
  logic               accept;
  logic               step;
  logic               last_step;

  // ---------------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept    = in_valid & in_ready;
  assign step      = (state_q == RUN);
  assign last_step = step & (idx_q == LAST_IDX);

  // ---------------------------------------------------------------------------
  // Datapath: one shared slice, operands selected by the slice index
  // ---------------------------------------------------------------------------
  assign slice_a = a_q[idx_q*SLICE_W +: SLICE_W];
  assign slice_b = b_q[idx_q*SLICE_W +: SLICE_W];

  addsub_slice #(
    .W (SLICE_W)
  ) u_slice (
    .cout (slice_cout),
    .sum  (slice_sum),
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  // Operand registers are reset along with the control state, so an aborted
  // operation leaves nothing behind for the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= sub ? ~b : b;
      carry_q <= sub;             // +1 of the two's-complement negation
      idx_q   <= '0;
    end else if (step) begin
      sum_q[idx_q*SLICE_W +: SLICE_W] <= slice_sum;
      carry_q <= slice_cout;
      if (last_step) begin
        cout_q <= slice_cout;
        idx_q  <= '0;
      end else begin
        idx_q  <= idx_q + IDX_W'(1);
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule : addsub_serial

// File: tb/tb_addsub_serial.sv
// -----------------------------------------------------------------------------
// tb_addsub_serial
//   Directed and randomised checks of addsub_serial at default parameters.
// -----------------------------------------------------------------------------
module tb_addsub_serial;

  localparam int LAT      = 8;
  localparam int N_RANDOM = 4000;
  localparam int TIMEOUT  = 50;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  addsub_serial dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: full-width combinational ripple adder, {cout, sum}.
  function automatic logic [32:0] rca32s(input logic [31:0] x, input logic [31:0] y,
                                         input logic s);
    return {1'b0, x} + {1'b0, (s ? ~y : y)} + 33'(s);
  endfunction

  // Present a request, wait for acceptance, then scramble the inputs so any
  // late sampling shows up in the result. Returns at accept edge + 1.
  task automatic start_op(input logic [31:0] oa, input logic [31:0] ob, input logic os);
    int w;
    @(negedge clk);
    in_valid = 1'b1;
    a = oa;
    b = ob;
    sub = os;
    w = 0;
    while (!in_ready && w < TIMEOUT) begin
      @(negedge clk);
      w++;
    end
    if (w >= TIMEOUT) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = ~oa;
    b = ~ob;
    sub = ~os;
  endtask

  // Counts edges after the accept edge until out_valid is seen.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < TIMEOUT) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic finish_op(input int stall);
    repeat (stall) @(negedge clk);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [31:0] oa, input logic [31:0] ob,
                        input logic os, input logic [31:0] exp_sum, input logic exp_cout);
    int lat;
    start_op(oa, ob, os);
    wait_done(lat);
    check({tag, "_lat"}, 64'(lat), 64'(LAT));
    check({tag, "_sum"}, 64'(sum), 64'(exp_sum));
    check({tag, "_cout"}, 64'(cout), 64'(exp_cout));
    finish_op(0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic        seen;
    logic [31:0] ra, rb;
    logic        rs;
    logic [32:0] exp33;
    int unsigned seed_dummy;

    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    sub = 1'b0;
    out_ready = 1'b0;

    // Reset values
    #12;
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum",       64'(sum),       64'd0);
    check("rst_cout",      64'(cout),      64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1. Add with full carry ripple
    run_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);
    run_op("add_msb",  32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1);

    // 2. Subtraction borrow / no-borrow
    run_op("sub_neg",  32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0);
    run_op("sub_eq",   32'h0000_0007, 32'h0000_0007, 1'b1, 32'h0000_0000, 1'b1);
    run_op("sub_zero", 32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0);

    // 3. Backpressure in DONE while a new request waits
    start_op(32'h1000_0000, 32'h0000_0001, 1'b0);
    wait_done(lat);
    check("bp_lat", 64'(lat), 64'(LAT));
    @(negedge clk);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a = $urandom;
      b = $urandom;
      sub = i[0];
      @(negedge clk);
      check("bp_hold", {31'd0, out_valid, in_ready, cout, sum},
            {31'd0, 1'b1, 1'b0, 1'b0, 32'h1000_0001});
    end
    a = 32'h0000_0064;
    b = 32'h0000_0017;
    sub = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_after_hs", {62'd0, in_ready, out_valid}, {62'd0, 1'b1, 1'b0});
    @(posedge clk);                 // in_valid still high: accepted here
    #1;
    in_valid = 1'b0;
    a = '1;
    b = '1;
    wait_done(lat);
    check("bp_next_lat", 64'(lat), 64'(LAT));
    check("bp_next_sum", {31'd0, cout, sum}, {31'd0, 1'b0, 32'h0000_007B});
    finish_op(0);

    // 4. Reset in the middle of RUN
    start_op(32'h1234_5678, 32'h1111_1111, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("run_ready", {62'd0, in_ready, out_valid}, 64'd0);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_sum",       64'(sum),       64'd0);
    check("abort_cout",      64'(cout),      64'd0);
    check("abort_in_ready",  64'(in_ready),  64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen |= out_valid;
    end
    check("abort_no_result", 64'(seen), 64'd0);
    run_op("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0);

    // 5. Operands changed right after accept (start_op inverts them)
    run_op("late_chg", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0);

    // 6. Random operations against the reference adder
    seed_dummy = $urandom(0);
    for (int i = 0; i < N_RANDOM; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
      rs = 1'($urandom_range(0, 1));
      exp33 = rca32s(ra, rb, rs);
      start_op(ra, rb, rs);
      wait_done(lat);
      check("rand", {23'd0, 8'(lat), cout, sum}, {23'd0, 8'(LAT), exp33});
      if (n_err != 0) break;
      finish_op(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_addsub_serial
